pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 22 ++
 rtl/ras_stack.sv | 64 ++++++
 rtl/pc_gen.sv | 111 +++++++++++
 tb/tb_pc_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_gen_pkg
// Purpose : Shared definitions for the PC generator: next-PC operation
//           encodings and the instruction size in bytes.
// Revision: 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

  typedef enum logic [2:0] {
    NPC_PC4 = 3'd0,
    NPC_BEQ = 3'd1,
    NPC_BNE = 3'd2,
    NPC_JAL = 3'd3,
    NPC_BL  = 3'd4,
    NPC_RET = 3'd5
  } npc_op_e;

  localparam int INST_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module  : ras_stack
// Purpose : Circular return-address stack. A push when full overwrites the
//           oldest entry; a pop when empty is ignored.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           push, push_data - write push_data at the write pointer
//           pop             - discard the top entry (ignored when empty)
//           top             - most recently pushed valid entry
//           count           - number of valid entries (0..DEPTH)
// Revision: 1.0 - initial release
// ============================================================================
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [XLEN-1:0]            push_data,
  output logic [XLEN-1:0]            top,
  output logic [$clog2(DEPTH):0]     count
);
  import pc_gen_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] C_ONE  = PW'(1);
  localparam logic [PW:0]   C_FULL = (PW + 1)'(DEPTH);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_ptr;   // next slot to write; top lives at r_ptr-1
  logic [PW:0]     r_count;
  logic [PW-1:0]   w_top_idx;

  assign w_top_idx = r_ptr - C_ONE;
  assign top       = r_mem[w_top_idx];
  assign count     = r_count;

  // Entry contents are deliberately not reset; r_count gates their use.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      r_mem[r_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      // Pointer wraps naturally, so a full push lands on the oldest entry.
      r_ptr <= r_ptr + C_ONE;
      if (r_count != C_FULL) begin
        r_count <= r_count + 1'b1;
      end
    end else if (pop && (r_count != '0)) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : pc_gen
// Purpose : Program-counter generator with branch/jump next-PC selection,
//           redirect (flush), stall, sticky misalignment flag and an optional
//           return-address stack.
// Config  : PC_GEN_RAS_EN - when defined, BL pushes pc+4 and RET pops from a
//           ras_stack instance; when undefined, RET behaves as JAL and
//           ras_count is tied to 0.
// Ports   : clk, rst                  - clock, synchronous active-high reset
//           stall                     - hold pc and RAS
//           flush_valid, flush_target - redirect request and address
//           npc_op, br, offset, jal_npc - next-PC operation and operands
//           pc, pc4, npc              - current, sequential and next address
//           misalign_err              - sticky misaligned-target flag
//           ras_count                 - valid RAS entries
// Revision: 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          flush_valid,
  input  logic [XLEN-1:0]               flush_target,
  input  logic [2:0]                    npc_op,
  input  logic                          br,
  input  logic [XLEN-1:0]               offset,
  input  logic [XLEN-1:0]               jal_npc,
  output logic [XLEN-1:0]               pc,
  output logic [XLEN-1:0]               pc4,
  output logic [XLEN-1:0]               npc,
  output logic                          misalign_err,
  output logic [$clog2(RAS_DEPTH):0]    ras_count
);
  import pc_gen_pkg::*;

  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_valid;

  assign pc           = r_pc;
  assign misalign_err = r_misalign;
  assign pc4          = r_pc + XLEN'(INST_BYTES);
  assign w_br_tgt     = r_pc + offset;

`ifdef PC_GEN_RAS_EN
  logic w_advance;
  logic w_push;
  logic w_pop;

  // Only a normal (unflushed, unstalled) update may touch the stack.
  assign w_advance   = !flush_valid && !stall;
  assign w_push      = w_advance && (npc_op == NPC_BL);
  assign w_pop       = w_advance && (npc_op == NPC_RET) && w_ras_valid;
  assign w_ras_valid = (ras_count != '0);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .XLEN  (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (pc4),
    .top       (w_ras_top),
    .count     (ras_count)
  );
`else
  assign w_ras_valid = 1'b0;
  assign w_ras_top   = '0;
  assign ras_count   = '0;
`endif

  always_comb begin
    npc = pc4;
    case (npc_op)
      NPC_BEQ: npc = br  ? w_br_tgt : pc4;
      NPC_BNE: npc = !br ? w_br_tgt : pc4;
      NPC_JAL: npc = jal_npc;
      NPC_BL:  npc = w_br_tgt;
      NPC_RET: npc = w_ras_valid ? w_ras_top : jal_npc;
      default: npc = pc4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (flush_valid) begin
      r_pc <= {flush_target[XLEN-1:2], 2'b00};
      if (flush_target[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end else if (!stall) begin
      r_pc <= {npc[XLEN-1:2], 2'b00};
      if (npc[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_gen
// Purpose : Directed self-checking bench for pc_gen (XLEN=32, RESET_PC=0,
//           RAS_DEPTH=4). Expected pc values go through a scoreboard queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush_valid;
  logic [31:0] flush_target;
  logic [2:0]  npc_op;
  logic        br;
  logic [31:0] offset;
  logic [31:0] jal_npc;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] npc;
  logic        misalign_err;
  logic [2:0]  ras_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  pc_gen #(
    .XLEN      (32),
    .RESET_PC  (32'h0),
    .RAS_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush_valid  (flush_valid),
    .flush_target (flush_target),
    .npc_op       (npc_op),
    .br           (br),
    .offset       (offset),
    .jal_npc      (jal_npc),
    .pc           (pc),
    .pc4          (pc4),
    .npc          (npc),
    .misalign_err (misalign_err),
    .ras_count    (ras_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expected pc, clock once, then compare against the popped value.
  task automatic cyc(input string tag, input logic [31:0] exp_pc);
    exp_q.push_back(exp_pc);
    @(posedge clk);
    #1;
    chk(tag, pc, exp_q.pop_front());
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; flush_valid = 1'b0;
    npc_op = NPC_PC4; br = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    idle();
    flush_valid = 1'b1; flush_target = tgt;
    cyc("redirect", {tgt[31:2], 2'b00});
    flush_valid = 1'b0;
  endtask

  initial begin
    // Reset dominates flush and stall.
    rst = 1'b1; stall = 1'b1; flush_valid = 1'b1; flush_target = 32'h100;
    npc_op = NPC_PC4; br = 1'b0; offset = '0; jal_npc = '0;
    cyc("reset_pc", 32'h0);
    chk("reset_misalign", 32'(misalign_err), 32'h0);
    chk("reset_ras_count", 32'(ras_count), 32'h0);

    idle();
    chk("npc_after_reset", npc, 32'h4);
    cyc("first_pc4", 32'h4);

    // Branches from 0x1000 with a negative offset.
    offset = 32'hFFFF_FFF0;
    redirect(32'h1000); npc_op = NPC_BEQ; br = 1'b1; cyc("beq_taken",    32'h1000 + 32'hFFFF_FFF0);
    redirect(32'h1000); npc_op = NPC_BEQ; br = 1'b0; cyc("beq_nottaken", 32'h1004);
    redirect(32'h1000); npc_op = NPC_BNE; br = 1'b0; cyc("bne_taken",    32'h0FF0);
    redirect(32'h1000); npc_op = NPC_BNE; br = 1'b1; cyc("bne_nottaken", 32'h1004);

    // Sequential wrap at the top of the address space.
    redirect(32'hFFFF_FFFC);
    chk("pc4_wrap", pc4, 32'h0);
    npc_op = NPC_PC4; cyc("pc_wrap", 32'h0);

    // Stall holds pc.
    stall = 1'b1; cyc("stall_hold", 32'h0);
    stall = 1'b0;

    // Indirect jump and undefined encodings.
    npc_op = NPC_JAL; jal_npc = 32'h300; cyc("jal", 32'h300);
    npc_op = 3'd7; cyc("op_undefined", 32'h304);
    chk("misalign_still_clear", 32'(misalign_err), 32'h0);

    // Misaligned redirect while stalled: flush wins, flag sets and sticks.
    stall = 1'b1; flush_valid = 1'b1; flush_target = 32'h2002;
    cyc("flush_over_stall", 32'h2000);
    chk("misalign_set_flush", 32'(misalign_err), 32'h1);
    idle(); cyc("pc4_after_flush", 32'h2004);
    chk("misalign_sticky", 32'(misalign_err), 32'h1);

    // Reset clears the flag; a misaligned computed target sets it again.
    rst = 1'b1; cyc("reset_again", 32'h0);
    chk("misalign_cleared", 32'(misalign_err), 32'h0);
    idle(); npc_op = NPC_JAL; jal_npc = 32'h502; cyc("jal_misaligned", 32'h500);
    chk("misalign_set_npc", 32'(misalign_err), 32'h1);

`ifdef PC_GEN_RAS_EN
    rst = 1'b1; cyc("ras_reset", 32'h0);
    offset = 32'h100;
    for (int i = 1; i <= 5; i++) begin
      redirect(32'(i * 16));
      npc_op = NPC_BL; cyc("bl", 32'(i * 16) + 32'h100);
      chk("bl_count", 32'(ras_count), (i < 4) ? 32'(i) : 32'h4);
    end
    jal_npc = 32'h900;
    for (int i = 5; i >= 2; i--) begin
      idle(); npc_op = NPC_RET; cyc("ret", 32'(i * 16) + 32'h4);
      chk("ret_count", 32'(ras_count), 32'(i - 2));
    end
    npc_op = NPC_RET; cyc("ret_empty", 32'h900);
    chk("ret_empty_count", 32'(ras_count), 32'h0);

    // Stall blocks a push; flush blocks a pop.
    redirect(32'h700); npc_op = NPC_BL; cyc("bl_one", 32'h800);
    chk("bl_one_count", 32'(ras_count), 32'h1);
    stall = 1'b1; npc_op = NPC_BL; cyc("stall_bl", 32'h800);
    chk("stall_bl_count", 32'(ras_count), 32'h1);
    stall = 1'b0; flush_valid = 1'b1; flush_target = 32'h600; npc_op = NPC_RET;
    cyc("flush_ret", 32'h600);
    chk("flush_ret_count", 32'(ras_count), 32'h1);

    // Reset discards the stack; next RET takes jal_npc.
    idle(); rst = 1'b1; cyc("ras_reset_mid", 32'h0);
    chk("ras_reset_count", 32'(ras_count), 32'h0);
    idle(); npc_op = NPC_RET; cyc("ret_after_reset", 32'h900);
`else
    redirect(32'h40);
    offset = 32'h100; npc_op = NPC_BL; cyc("bl_noras", 32'h140);
    chk("bl_noras_count", 32'(ras_count), 32'h0);
    jal_npc = 32'h800; npc_op = NPC_RET; cyc("ret_as_jal", 32'h800);
    chk("ret_noras_count", 32'(ras_count), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
